// File: rtl/irq_source.sv
// irq_source: per-channel debounced interrupt request source.
//
// Each channel synchronizes a raw asynchronous request line, debounces it,
// and turns an armed 0->1 transition of the debounced level into a pending
// request held on irq_src_o until the interrupt controller takes it.
// A request that arrives while the previous one is still pending is flagged
// in a sticky overrun bit.
//
// Ports
//   clk_i       : single clock, all state updates on the rising edge
//   rst_i       : asynchronous, active-high reset
//   en_i        : controller sample enable; a cycle with en_i=1 and
//                 irq_src_o=1 delivers the request, which then clears
//   btn_i       : [`NIRQ] raw asynchronous request lines
//   mask_i      : [`NIRQ] per-channel arm, checked only at event time
//   ovr_clr_i   : [`NIRQ] per-channel overrun clear
//   irq_src_o   : [`NIRQ] registered pending request lines
//   overrun_o   : [`NIRQ] sticky lost-request flags

`ifndef NIRQ
`define NIRQ 4
`endif

module irq_source #(
    parameter int DEB_CYCLES = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [`NIRQ-1:0]  btn_i,
    input  logic [`NIRQ-1:0]  mask_i,
    input  logic [`NIRQ-1:0]  ovr_clr_i,
    output logic [`NIRQ-1:0]  irq_src_o,
    output logic [`NIRQ-1:0]  overrun_o
);

    localparam int NIRQ = `NIRQ;
    // Terminal count: stable flips on the edge where the counter sits here.
    localparam logic [15:0] DEB_LAST = 16'(DEB_CYCLES - 1);

    logic [NIRQ-1:0]        s1_q;
    logic [NIRQ-1:0]        s2_q;
    logic [NIRQ-1:0]        stable_q;
    logic [NIRQ-1:0]        stable_d;
    logic [NIRQ-1:0][15:0]  cnt_q;
    logic [NIRQ-1:0][15:0]  cnt_d;
    logic [NIRQ-1:0]        irq_q;
    logic [NIRQ-1:0]        irq_d;
    logic [NIRQ-1:0]        ovr_q;
    logic [NIRQ-1:0]        ovr_d;
    logic [NIRQ-1:0]        event_s;
    logic [NIRQ-1:0]        hs_clr_s;
    logic [NIRQ-1:0]        ovr_set_s;

    // Two-flop synchronizer for the raw request lines.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= btn_i;
            s2_q <= s1_q;
        end
    end

    // Debounce next state and rising-edge event detection.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        event_s  = '0;
        for (int i = 0; i < NIRQ; i++) begin
            if (s2_q[i] == stable_q[i]) begin
                cnt_d[i] = 16'd0;
            end else if (cnt_q[i] == DEB_LAST) begin
                // Level has differed for DEB_CYCLES consecutive cycles.
                stable_d[i] = s2_q[i];
                cnt_d[i]    = 16'd0;
                // Only an armed rise is an event; mask is sampled here only.
                event_s[i]  = s2_q[i] & mask_i[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
    end

    // Pending request and overrun next state.
    always_comb begin
        // The controller saw irq_src_o during this cycle if en_i was high.
        hs_clr_s  = {NIRQ{en_i}} & irq_q;
        // A new event wins over a coincident handshake clear, and only an
        // event on a request that is not being delivered is an overrun.
        irq_d     = (irq_q & ~hs_clr_s) | event_s;
        ovr_set_s = event_s & irq_q & ~hs_clr_s;
        // Set beats a coincident clear.
        ovr_d     = ovr_set_s | (ovr_q & ~ovr_clr_i);
    end

    // Debounce, pending and overrun state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stable_q <= '0;
            cnt_q    <= '0;
            irq_q    <= '0;
            ovr_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            irq_q    <= irq_d;
            ovr_q    <= ovr_d;
        end
    end

    assign irq_src_o = irq_q;
    assign overrun_o = ovr_q;

endmodule

// File: tb/tb_irq_source.sv
// Directed self-checking bench for irq_source (DEB_CYCLES=4 main instance,
// plus a DEB_CYCLES=1 instance for the shortest debounce).

`ifndef NIRQ
`define NIRQ 4
`endif

module tb_irq_source;

    localparam int N = `NIRQ;

    logic          clk;
    logic          rst;
    logic          en;
    logic [N-1:0]  btn;
    logic [N-1:0]  mask;
    logic [N-1:0]  ovr_clr;
    logic [N-1:0]  irq_src;
    logic [N-1:0]  overrun;
    logic [N-1:0]  irq_src1;
    logic [N-1:0]  overrun1;

    int tests_run;
    int tests_failed;

    irq_source #(.DEB_CYCLES(4)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .en_i      (en),
        .btn_i     (btn),
        .mask_i    (mask),
        .ovr_clr_i (ovr_clr),
        .irq_src_o (irq_src),
        .overrun_o (overrun)
    );

    irq_source #(.DEB_CYCLES(1)) dut1 (
        .clk_i     (clk),
        .rst_i     (rst),
        .en_i      (en),
        .btn_i     (btn),
        .mask_i    (mask),
        .ovr_clr_i (ovr_clr),
        .irq_src_o (irq_src1),
        .overrun_o (overrun1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, leaving time 1 unit past the last edge.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; btn = '0; mask = '1; ovr_clr = '0;
        tick(2);
        tests_run++;
        if (irq_src !== 4'b0000 || overrun !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_state: irq_src=%b overrun=%b want 0000/0000", irq_src, overrun);
        end
        rst = 1'b0;
        tick(1);
        tests_run++;
        if (irq_src !== 4'b0000 || overrun !== 4'b0000) begin
            tests_failed++;
            $display("FAIL after_release: irq_src=%b overrun=%b want 0000/0000", irq_src, overrun);
        end
    endtask

    task automatic test_basic();
        btn[0] = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick(1);
            tests_run++;
            if (irq_src[0] !== (e == 6)) begin
                tests_failed++;
                $display("FAIL basic_latency edge %0d: irq_src[0]=%b want %b", e, irq_src[0], (e == 6));
            end
        end
        tick(10);
        tests_run++;
        if (irq_src[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_hold: irq_src[0]=%b want 1", irq_src[0]);
        end
        en = 1'b1;
        tick(1);
        en = 1'b0;
        tests_run++;
        if (irq_src[0] !== 1'b0 || overrun[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_handshake: irq_src[0]=%b overrun[0]=%b want 0/0", irq_src[0], overrun[0]);
        end
        btn[0] = 1'b0;
        tick(8);
        tests_run++;
        if (irq_src[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_release_no_event: irq_src[0]=%b want 0", irq_src[0]);
        end
    endtask

    task automatic test_glitch();
        // Three cycles high drives the counter to DEB_CYCLES-1 without flipping.
        btn[1] = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            if (e == 4) btn[1] = 1'b0;
            tick(1);
            tests_run++;
            if (irq_src[1] !== 1'b0 || dut.stable_q[1] !== 1'b0) begin
                tests_failed++;
                $display("FAIL glitch edge %0d: irq_src[1]=%b stable[1]=%b want 0/0", e, irq_src[1], dut.stable_q[1]);
            end
        end
    endtask

    task automatic test_overrun();
        btn[2] = 1'b1;
        tick(6);
        tests_run++;
        if (irq_src[2] !== 1'b1 || overrun[2] !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovr_first_press: irq_src[2]=%b overrun[2]=%b want 1/0", irq_src[2], overrun[2]);
        end
        btn[2] = 1'b0;
        tick(14);
        btn[2] = 1'b1;
        tick(5);
        tests_run++;
        if (irq_src[2] !== 1'b1 || overrun[2] !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovr_before_event: irq_src[2]=%b overrun[2]=%b want 1/0", irq_src[2], overrun[2]);
        end
        tick(1);
        tests_run++;
        if (irq_src[2] !== 1'b1 || overrun[2] !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovr_set: irq_src[2]=%b overrun[2]=%b want 1/1", irq_src[2], overrun[2]);
        end
        ovr_clr[2] = 1'b1;
        tick(1);
        ovr_clr[2] = 1'b0;
        tests_run++;
        if (irq_src[2] !== 1'b1 || overrun[2] !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovr_clear: irq_src[2]=%b overrun[2]=%b want 1/0", irq_src[2], overrun[2]);
        end
        // Third press with ovr_clr held on the event edge: set must win.
        btn[2] = 1'b0;
        tick(8);
        btn[2] = 1'b1;
        tick(5);
        ovr_clr[2] = 1'b1;
        tick(1);
        ovr_clr[2] = 1'b0;
        tests_run++;
        if (overrun[2] !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovr_set_wins: overrun[2]=%b want 1", overrun[2]);
        end
        ovr_clr[2] = 1'b1;
        tick(1);
        ovr_clr[2] = 1'b0;
        en = 1'b1;
        tick(1);
        en = 1'b0;
        tests_run++;
        if (irq_src[2] !== 1'b0 || overrun[2] !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovr_cleanup: irq_src[2]=%b overrun[2]=%b want 0/0", irq_src[2], overrun[2]);
        end
        btn[2] = 1'b0;
        tick(8);
    endtask

    task automatic test_coincide();
        btn[3] = 1'b1;
        tick(6);
        btn[3] = 1'b0;
        tick(8);
        tests_run++;
        if (irq_src[3] !== 1'b1) begin
            tests_failed++;
            $display("FAIL coincide_pending: irq_src[3]=%b want 1", irq_src[3]);
        end
        btn[3] = 1'b1;
        tick(5);
        en = 1'b1;
        tick(1);
        tests_run++;
        if (irq_src[3] !== 1'b1 || overrun[3] !== 1'b0) begin
            tests_failed++;
            $display("FAIL coincide_event_clear: irq_src[3]=%b overrun[3]=%b want 1/0", irq_src[3], overrun[3]);
        end
        tick(1);
        en = 1'b0;
        tests_run++;
        if (irq_src[3] !== 1'b0 || overrun[3] !== 1'b0) begin
            tests_failed++;
            $display("FAIL coincide_second_en: irq_src[3]=%b overrun[3]=%b want 0/0", irq_src[3], overrun[3]);
        end
        btn[3] = 1'b0;
        tick(8);
    endtask

    task automatic test_mask();
        mask[0] = 1'b0;
        btn[0] = 1'b1;
        tick(10);
        tests_run++;
        if (irq_src[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL mask_blocks: irq_src[0]=%b want 0", irq_src[0]);
        end
        btn[0] = 1'b0;
        tick(8);
        mask[0] = 1'b1;
        btn[0] = 1'b1;
        tick(6);
        mask[0] = 1'b0;
        tick(5);
        tests_run++;
        if (irq_src[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL mask_no_clear: irq_src[0]=%b want 1", irq_src[0]);
        end
        en = 1'b1;
        tick(1);
        en = 1'b0;
        tests_run++;
        if (irq_src[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL mask_handshake: irq_src[0]=%b want 0", irq_src[0]);
        end
        mask[0] = 1'b1;
        btn[0] = 1'b0;
        tick(8);
    endtask

    task automatic test_reset_pending();
        btn[0] = 1'b1;
        tick(6);
        tests_run++;
        if (irq_src[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstp_pending: irq_src[0]=%b want 1", irq_src[0]);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (irq_src !== 4'b0000 || overrun !== 4'b0000) begin
            tests_failed++;
            $display("FAIL rstp_async: irq_src=%b overrun=%b want 0000/0000", irq_src, overrun);
        end
        tick(2);
        rst = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick(1);
            tests_run++;
            if (irq_src[0] !== (e == 6)) begin
                tests_failed++;
                $display("FAIL rstp_latency edge %0d: irq_src[0]=%b want %b", e, irq_src[0], (e == 6));
            end
        end
        en = 1'b1;
        tick(1);
        en = 1'b0;
        tick(10);
        tests_run++;
        if (irq_src[0] !== 1'b0 || overrun[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstp_single: irq_src[0]=%b overrun[0]=%b want 0/0", irq_src[0], overrun[0]);
        end
        btn[0] = 1'b0;
        tick(8);
    endtask

    task automatic test_deb1();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        btn[0] = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick(1);
            tests_run++;
            if (irq_src1[0] !== (e == 3)) begin
                tests_failed++;
                $display("FAIL deb1_latency edge %0d: irq_src[0]=%b want %b", e, irq_src1[0], (e == 3));
            end
        end
        btn[0] = 1'b0;
        tick(4);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_basic();
        test_glitch();
        test_overrun();
        test_coincide();
        test_mask();
        test_reset_pending();
        test_deb1();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
